// File: rtl/pe_control_mc_pkg.sv
// pe_control_mc_pkg: shared types and helpers for the PE control block.
//   pe_state_e : FSM state encoding (IDLE=0, ACCUM=1, FLUSH=2)
//   ch_w()     : channel-select width, max(1, clog2(num_ch))
//   almfull()  : drain FIFO almost-full test, (depth - usedw) < margin
package pe_control_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } pe_state_e;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Signed arithmetic so a usedw above depth still reads as almost full.
    function automatic logic almfull(input int depth, input int usedw, input int margin);
        return (depth - usedw) < margin;
    endfunction

endpackage

// File: rtl/pe_ctrl_delay.sv
// pe_ctrl_delay: fixed-length shift register, W bits wide, LEN cycles deep.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : synchronous flush of every stage (in-flight beats dropped)
//   i_d / o_q  : data in / data out LEN cycles later (LEN >= 2)
module pe_ctrl_delay #(
    parameter int W   = 1,
    parameter int LEN = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [LEN-1:0][W-1:0] r_pipe;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) r_pipe <= '0;
        else                 r_pipe <= {r_pipe[LEN-2:0], i_d};
    end

    assign o_q = r_pipe[LEN-1];

endmodule

// File: rtl/pe_control_mc.sv
// pe_control_mc: control for a multi-channel accumulating PE with drain chain.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ena/acc_fin/acc_res/acc_stop    vector valid, last vector, use feedback, abort
//   ch_sel                          channel of the current vector
//   pe_dot_ena/pe_stall/pe_acc_fin  dot enable (const 1), upstream hold, delayed acc_fin
//   state, err                      FSM state, sticky drain collision/overflow flag
//   feed_*                          per-channel feedback FIFO control/status
//   drain_*, pe_drain_neig          drain FIFO control/status and chain handshake
// Build option: define PE_CONTROL_MC_PERF_EN to add 32-bit saturating
//   perf_stall_cyc / perf_drained counters.
module pe_control_mc
    import pe_control_mc_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_CH         = 4,
    parameter int DOT_DELAY      = 10,
    parameter int DRAIN_DEPTH    = 512,
    parameter int ALMFULL_MARGIN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         acc_fin,
    input  logic                         acc_res,
    input  logic                         acc_stop,
    input  logic [ch_w(NUM_CH)-1:0]      ch_sel,
    output logic                         pe_dot_ena,
    output logic                         pe_stall,
    output logic                         pe_acc_fin,
    output logic [1:0]                   state,
    output logic                         err,
`ifdef PE_CONTROL_MC_PERF_EN
    output logic [31:0]                  perf_stall_cyc,
    output logic [31:0]                  perf_drained,
`endif
    output logic [NUM_CH-1:0]            feed_wrreq,
    output logic [NUM_CH-1:0]            feed_rdreq,
    input  logic [NUM_CH-1:0]            feed_empty,
    input  logic [NUM_CH-1:0]            feed_full,
    output logic                         drain_wrreq,
    output logic                         drain_rdreq,
    input  logic                         drain_empty,
    input  logic                         drain_full,
    input  logic [$clog2(DRAIN_DEPTH):0] drain_usedw,
    output logic                         pe_drain_neig,
    input  logic                         drain_neig_valid,
    input  logic                         drain_neig_rdy,
    output logic                         drain_valid,
    output logic                         drain_rdy
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(DOT_DELAY);

    if (DATA_WIDTH < 1 || DOT_DELAY < 2 || ALMFULL_MARGIN < 2) begin : g_param_chk
        $error("pe_control_mc: illegal parameter value");
    end

    // ---- dot-chain delay line: {ena, acc_fin, ch_sel} ----
    logic            w_ena_q, w_acc_fin_q;
    logic [CH_W-1:0] w_ch_q;

    pe_ctrl_delay #(.W(CH_W + 2), .LEN(DOT_DELAY)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (acc_stop),
        .i_d   ({ena, acc_fin, ch_sel}),
        .o_q   ({w_ena_q, w_acc_fin_q, w_ch_q})
    );

    // ---- FSM ----
    pe_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_acc_fin_d, w_fin_fall, w_rdy_nxt, w_almfull;

    assign w_fin_fall = r_acc_fin_d & ~acc_fin;
    assign w_almfull  = almfull(DRAIN_DEPTH, int'(drain_usedw), ALMFULL_MARGIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_acc_fin_d <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc_fin_d <= acc_fin;
        end
    end

    // FLUSH lasts DOT_DELAY-1 cycles: counter loads DOT_DELAY-2, exits at 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (acc_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE:  if (ena) w_state_nxt = ST_ACCUM;
                ST_ACCUM: if (w_fin_fall) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = CNT_W'(DOT_DELAY - 2);
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) w_state_nxt = ena ? ST_ACCUM : ST_IDLE;
                    else             w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // drain_rdy looks at the next state so it is already low in the first
    // FLUSH cycle rather than one cycle late.
    always_comb begin
        state     = r_state;
        w_rdy_nxt = ~w_almfull & (w_state_nxt != ST_FLUSH) & ~acc_fin;
    end

    // ---- drain chain ----
    logic r_drain_rdy, r_neig_rdy, r_err;
    logic w_loc_wr, w_wr_req;

    assign w_loc_wr = w_ena_q & w_acc_fin_q;
    assign w_wr_req = w_loc_wr | drain_neig_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drain_rdy <= 1'b0;
            r_neig_rdy  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_drain_rdy <= w_rdy_nxt;
            r_neig_rdy  <= drain_neig_rdy;
            if ((w_loc_wr & drain_neig_valid) | (w_wr_req & drain_full)) r_err <= 1'b1;
        end
    end

    // Request outputs are gated by rst_n so nothing leaks out during reset.
    assign drain_wrreq   = rst_n & ~drain_full & w_wr_req;
    assign pe_drain_neig = ~w_loc_wr & drain_neig_valid;
    assign drain_rdreq   = rst_n & r_neig_rdy & ~drain_empty;
    assign drain_valid   = drain_rdreq;
    assign drain_rdy     = r_drain_rdy;
    assign err           = r_err;
    assign pe_stall      = acc_fin & w_almfull;
    assign pe_acc_fin    = w_acc_fin_q;
    assign pe_dot_ena    = 1'b1;

    // ---- feedback FIFOs ----
    always_comb begin
        feed_wrreq = '0;
        feed_rdreq = '0;
        if (rst_n && int'(w_ch_q) < NUM_CH &&
            w_ena_q && !w_acc_fin_q && !feed_full[w_ch_q])
            feed_wrreq[w_ch_q] = 1'b1;
        if (rst_n && int'(ch_sel) < NUM_CH &&
            ena && acc_res && !feed_empty[ch_sel])
            feed_rdreq[ch_sel] = 1'b1;
    end

`ifdef PE_CONTROL_MC_PERF_EN
    logic [31:0] r_perf_stall, r_perf_drained;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall   <= '0;
            r_perf_drained <= '0;
        end else begin
            if (pe_stall && r_perf_stall != '1)      r_perf_stall   <= r_perf_stall + 32'd1;
            if (drain_rdreq && r_perf_drained != '1) r_perf_drained <= r_perf_drained + 32'd1;
        end
    end

    assign perf_stall_cyc = r_perf_stall;
    assign perf_drained   = r_perf_drained;
`endif

endmodule

// File: tb/tb_pe_control_mc.sv
// tb_pe_control_mc: directed-vector bench for pe_control_mc
// (NUM_CH=4, DOT_DELAY=10, DRAIN_DEPTH=512, ALMFULL_MARGIN=4).
// Cycle c begins at a rising edge; inputs change 1 time unit after it and
// outputs are sampled 2 units later.
module tb_pe_control_mc;

    localparam int NUM_CH = 4;
    localparam int UW     = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 0, acc_fin = 0, acc_res = 0, acc_stop = 0;
    logic [1:0]        ch_sel = '0;
    logic              pe_dot_ena, pe_stall, pe_acc_fin, err;
    logic [1:0]        state;
    logic [NUM_CH-1:0] feed_wrreq, feed_rdreq;
    logic [NUM_CH-1:0] feed_empty = '0, feed_full = '0;
    logic              drain_wrreq, drain_rdreq, pe_drain_neig, drain_valid, drain_rdy;
    logic              drain_empty = 1'b1, drain_full = 1'b0;
    logic [UW-1:0]     drain_usedw = '0;
    logic              drain_neig_valid = 1'b0, drain_neig_rdy = 1'b0;
`ifdef PE_CONTROL_MC_PERF_EN
    logic [31:0]       perf_stall_cyc, perf_drained;
`endif

    pe_control_mc #(
        .DATA_WIDTH(16), .NUM_CH(NUM_CH), .DOT_DELAY(10),
        .DRAIN_DEPTH(512), .ALMFULL_MARGIN(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .acc_fin(acc_fin), .acc_res(acc_res),
        .acc_stop(acc_stop), .ch_sel(ch_sel), .pe_dot_ena(pe_dot_ena),
        .pe_stall(pe_stall), .pe_acc_fin(pe_acc_fin), .state(state), .err(err),
`ifdef PE_CONTROL_MC_PERF_EN
        .perf_stall_cyc(perf_stall_cyc), .perf_drained(perf_drained),
`endif
        .feed_wrreq(feed_wrreq), .feed_rdreq(feed_rdreq), .feed_empty(feed_empty),
        .feed_full(feed_full), .drain_wrreq(drain_wrreq), .drain_rdreq(drain_rdreq),
        .drain_empty(drain_empty), .drain_full(drain_full), .drain_usedw(drain_usedw),
        .pe_drain_neig(pe_drain_neig), .drain_neig_valid(drain_neig_valid),
        .drain_neig_rdy(drain_neig_rdy), .drain_valid(drain_valid), .drain_rdy(drain_rdy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset: requests held low even with active inputs ----
        rst_n = 0; ena = 1; acc_res = 1; ch_sel = 2'd1;
        drain_neig_valid = 1; drain_neig_rdy = 1; drain_empty = 0;
        repeat (3) step();
        #2;
        chk("rst_feed_rdreq", 32'(feed_rdreq), 32'h0);
        chk("rst_feed_wrreq", 32'(feed_wrreq), 32'h0);
        chk("rst_drain_wrreq", 32'(drain_wrreq), 32'h0);
        chk("rst_drain_rdreq", 32'(drain_rdreq), 32'h0);
        chk("rst_drain_valid", 32'(drain_valid), 32'h0);
        chk("rst_dot_ena", 32'(pe_dot_ena), 32'h1);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_drain_rdy", 32'(drain_rdy), 32'h0);
        step();
        rst_n = 1; ena = 0; acc_res = 0; ch_sel = '0;
        drain_neig_valid = 0; drain_neig_rdy = 0; drain_empty = 1;
        repeat (2) step();

        // ---- feedback write on channel 2 exactly DOT_DELAY later ----
        for (int c = 0; c <= 12; c++) begin
            step();
            ena = (c == 0); acc_res = (c == 0); ch_sel = 2'd2;
            #2;
            if (c == 0) chk("feed_rdreq_ch2", 32'(feed_rdreq), 32'h4);
            chk($sformatf("feed_wrreq_c%0d", c), 32'(feed_wrreq), (c == 10) ? 32'h4 : 32'h0);
        end
        // empty feedback FIFO blocks the read
        step(); ena = 1; acc_res = 1; feed_empty = 4'b0100;
        #2; chk("feed_rdreq_empty", 32'(feed_rdreq), 32'h0);
        // abort: back to IDLE, pending feedback write dropped
        step(); ena = 0; acc_res = 0; feed_empty = '0; acc_stop = 1;
        step(); acc_stop = 0;
        #2; chk("stop_state_idle", 32'(state), 32'h0);
        for (int c = 0; c < 11; c++) begin
            step(); #2;
            chk($sformatf("stop_no_feed_c%0d", c), 32'(feed_wrreq), 32'h0);
        end

        // ---- accumulate with acc_fin on cycles 5-7, then FLUSH ----
        for (int c = 0; c <= 19; c++) begin
            step();
            ena = (c <= 7); acc_fin = (c >= 5 && c <= 7); ch_sel = 2'd1;
            #2;
            chk($sformatf("acc_drain_wr_c%0d", c), 32'(drain_wrreq), (c >= 15 && c <= 17) ? 32'h1 : 32'h0);
            chk($sformatf("acc_pe_fin_c%0d", c), 32'(pe_acc_fin), (c >= 15 && c <= 17) ? 32'h1 : 32'h0);
            chk($sformatf("acc_feed_wr_c%0d", c), 32'(feed_wrreq), (c >= 10 && c <= 14) ? 32'h2 : 32'h0);
            chk($sformatf("acc_state_c%0d", c), 32'(state),
                (c == 0 || c >= 18) ? 32'h0 : (c <= 8) ? 32'h1 : 32'h2);
            chk($sformatf("acc_drain_rdy_c%0d", c), 32'(drain_rdy), (c >= 6 && c <= 17) ? 32'h0 : 32'h1);
        end

        // ---- almost-full boundary: 512-509=3 < 4, 512-508=4 not < 4 ----
        step(); ena = 0; acc_fin = 1; drain_usedw = 10'd509;
        #2; chk("stall_usedw509", 32'(pe_stall), 32'h1);
        step(); drain_usedw = 10'd508;
        #2; chk("rdy_after_stall", 32'(drain_rdy), 32'h0);
        chk("stall_usedw508", 32'(pe_stall), 32'h0);
        step(); acc_fin = 0;
        #2; chk("stall_no_fin", 32'(pe_stall), 32'h0);
        step(); drain_usedw = 10'd509;
        #2; chk("rdy_usedw508", 32'(drain_rdy), 32'h1);
        chk("stall_almfull_no_fin", 32'(pe_stall), 32'h0);
        step(); drain_usedw = '0;
        #2; chk("rdy_usedw509", 32'(drain_rdy), 32'h0);
        chk("idle_after_fin_only", 32'(state), 32'h0);
        repeat (10) step();

        // ---- drain read one cycle after neighbour ready ----
        step(); drain_empty = 0; drain_neig_rdy = 1;
        #2; chk("rdreq_at_N", 32'(drain_rdreq), 32'h0);
        step(); drain_neig_rdy = 0;
        #2; chk("rdreq_N1", 32'(drain_rdreq), 32'h1);
        chk("valid_N1", 32'(drain_valid), 32'h1);
        step();
        #2; chk("rdreq_N2", 32'(drain_rdreq), 32'h0);
        chk("valid_N2", 32'(drain_valid), 32'h0);
        step(); drain_empty = 1; drain_neig_rdy = 1;
        step(); drain_neig_rdy = 0;
        #2; chk("rdreq_empty", 32'(drain_rdreq), 32'h0);
        chk("valid_empty", 32'(drain_valid), 32'h0);

        // ---- local result collides with neighbour beat ----
        for (int c = 0; c <= 16; c++) begin
            step();
            ena = (c <= 3); acc_fin = (c >= 2 && c <= 3);
            drain_neig_valid = (c == 12 || c == 15 || c == 16);
            drain_full = (c == 16);
            #2;
            if (c == 5)  chk("col_state_flush", 32'(state), 32'h2);
            if (c == 11) chk("col_err_before", 32'(err), 32'h0);
            if (c == 12) begin
                chk("col_wrreq", 32'(drain_wrreq), 32'h1);
                chk("col_neig_sel", 32'(pe_drain_neig), 32'h0);
            end
            if (c == 13) begin
                chk("col_err_set", 32'(err), 32'h1);
                chk("col_local_wr", 32'(drain_wrreq), 32'h1);
            end
            if (c == 15) begin
                chk("neig_wrreq", 32'(drain_wrreq), 32'h1);
                chk("neig_sel", 32'(pe_drain_neig), 32'h1);
            end
            if (c == 16) begin
                chk("full_wrreq", 32'(drain_wrreq), 32'h0);
                chk("err_held", 32'(err), 32'h1);
            end
        end
        step(); drain_neig_valid = 0; drain_full = 0;

        // ---- acc_stop mid-FLUSH: no later writes ----
        for (int c = 0; c <= 16; c++) begin
            step();
            ena = (c <= 3); acc_fin = (c >= 2 && c <= 3); acc_stop = (c == 7);
            #2;
            if (c == 6) chk("stop_in_flush", 32'(state), 32'h2);
            if (c == 8) chk("stop_to_idle", 32'(state), 32'h0);
            if (c >= 8) begin
                chk($sformatf("stop_drain_c%0d", c), 32'(drain_wrreq), 32'h0);
                chk($sformatf("stop_feed_c%0d", c), 32'(feed_wrreq), 32'h0);
            end
            if (c == 16) chk("stop_err_held", 32'(err), 32'h1);
        end

        // ---- reset mid-FLUSH: in-flight results discarded ----
        for (int c = 0; c <= 16; c++) begin
            step();
            ena = (c <= 3); acc_fin = (c >= 2 && c <= 3); rst_n = (c != 6);
            #2;
            if (c == 7) begin
                chk("rst_flush_state", 32'(state), 32'h0);
                chk("rst_flush_err", 32'(err), 32'h0);
            end
            if (c >= 7) begin
                chk($sformatf("rst_drain_c%0d", c), 32'(drain_wrreq), 32'h0);
                chk($sformatf("rst_feed_c%0d", c), 32'(feed_wrreq), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
